// File: rtl/jtag_scan_master.sv
// JTAG scan engine: DR/IR scans, TAP resets and Run-Test/Idle waits issued as one
// valid/ready command each. Define JTAG_SCAN_MASTER_MSB_FIRST_EN to add cmd_msb_first.
module jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CLK_DIV = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_tdi,
`ifdef JTAG_SCAN_MASTER_MSB_FIRST_EN
    input  logic               cmd_msb_first,
`endif
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_tdo,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    // Bit index must also cover the 6-bit TAP reset sequence.
    localparam int IDX_W = (LEN_W > 3) ? LEN_W : 3;
    localparam int CYC_W = $clog2(2 * CLK_DIV);

    typedef enum logic [2:0] {S_TAPRST, S_IDLE, S_PRE, S_SHIFT, S_POST, S_WAIT, S_DONE} state_e;
    typedef enum logic [1:0] {OP_DR, OP_IR, OP_RST, OP_WAIT} op_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic [IDX_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, rsp_tdo_q, rsp_tdo_d;
    logic               is_ir_q, is_ir_d, msb_q, msb_d, auto_q, auto_d;
    logic               load_bit;
    logic               msb_first_in;
    logic [LEN_W-1:0]   len_clamped;

`ifdef JTAG_SCAN_MASTER_MSB_FIRST_EN
    assign msb_first_in = cmd_msb_first;
`else
    assign msb_first_in = 1'b0;
`endif

    assign len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

    // Number of tck bits in each stepping state.
    function automatic logic [IDX_W-1:0] seg_len(input state_e st, input logic [IDX_W-1:0] len,
                                                 input logic ir);
        case (st)
            S_TAPRST:        return IDX_W'(6);
            S_PRE:           return ir ? IDX_W'(4) : IDX_W'(3);
            S_POST:          return IDX_W'(2);
            S_SHIFT, S_WAIT: return len;
            default:         return IDX_W'(1);
        endcase
    endfunction

    function automatic logic bit_tms(input state_e st, input logic [IDX_W-1:0] i,
                                     input logic [IDX_W-1:0] len, input logic ir);
        case (st)
            S_TAPRST: return i < IDX_W'(5);
            S_PRE:    return (i == '0) || (ir && i == IDX_W'(1));
            S_SHIFT:  return i == len - IDX_W'(1);
            S_POST:   return i == '0;
            default:  return 1'b0;
        endcase
    endfunction

    // One-hot select of the data bit used by shift bit i.
    function automatic logic [MAX_LEN-1:0] bit_mask(input logic [IDX_W-1:0] i,
                                                    input logic [IDX_W-1:0] len, input logic msb);
        logic [IDX_W-1:0] p;
        p = msb ? (len - i - IDX_W'(1)) : i;
        return MAX_LEN'(1) << p;
    endfunction

    // NOTE: every _d gets its default first, so no path through this block infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cyc_d     = cyc_q;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        len_d     = len_q;
        data_d    = data_q;
        is_ir_d   = is_ir_q;
        msb_d     = msb_q;
        auto_d    = auto_q;
        cap_d     = cap_q;
        rsp_tdo_d = rsp_tdo_q;
        load_bit  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (cmd_valid) begin
                    len_d    = IDX_W'(len_clamped);
                    data_d   = cmd_tdi;
                    is_ir_d  = (cmd_op == OP_IR);
                    msb_d    = msb_first_in;
                    auto_d   = 1'b0;
                    cap_d    = '0;
                    idx_d    = '0;
                    cyc_d    = '0;
                    load_bit = 1'b1;
                    case (cmd_op)
                        OP_RST:  state_d = S_TAPRST;
                        OP_WAIT: state_d = (len_clamped == '0) ? S_DONE : S_WAIT;
                        default: state_d = (len_clamped == '0) ? S_DONE : S_PRE;
                    endcase
                end
            end
            default: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == CYC_W'(CLK_DIV - 1)) begin
                    tck_d = 1'b1;
                    if (state_q == S_SHIFT && tdo) cap_d = cap_q | bit_mask(idx_q, len_q, msb_q);
                end
                if (cyc_q == CYC_W'(2 * CLK_DIV - 1)) begin
                    tck_d    = 1'b0;
                    cyc_d    = '0;
                    load_bit = 1'b1;
                    if (idx_q != seg_len(state_q, len_q, is_ir_q) - IDX_W'(1)) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = '0;
                        case (state_q)
                            S_TAPRST: state_d = auto_q ? S_IDLE : S_DONE;
                            S_PRE:    state_d = S_SHIFT;
                            S_SHIFT:  state_d = S_POST;
                            default:  state_d = S_DONE;
                        endcase
                    end
                end
            end
        endcase

        // tms/tdi change only on the first clock of a bit's low phase.
        if (state_d == S_IDLE || state_d == S_DONE) begin
            tms_d = 1'b0;
            tdi_d = 1'b0;
        end else if (load_bit) begin
            tms_d = bit_tms(state_d, idx_d, len_d, is_ir_d);
            tdi_d = (state_d == S_SHIFT) && |(data_q & bit_mask(idx_d, len_q, msb_q));
        end

        if (state_d == S_DONE) rsp_tdo_d = cap_d;
    end

    // NOTE: state registers use non-blocking assignments only, so every always_ff
    // samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_TAPRST;
            idx_q     <= '0;
            cyc_q     <= '0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b1;
            tdi_q     <= 1'b0;
            len_q     <= '0;
            data_q    <= '0;
            is_ir_q   <= 1'b0;
            msb_q     <= 1'b0;
            auto_q    <= 1'b1;
            cap_q     <= '0;
            rsp_tdo_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            len_q     <= len_d;
            data_q    <= data_d;
            is_ir_q   <= is_ir_d;
            msb_q     <= msb_d;
            auto_q    <= auto_d;
            cap_q     <= cap_d;
            rsp_tdo_q <= rsp_tdo_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy      = !cmd_ready;
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_tdo   = rsp_tdo_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: directed commands against a behavioural TAP; responses
// are checked by a scoreboard monitor, tms/tdi bit streams after each command.
module tb_jtag_scan_master;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam int CLK_DIV = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = '0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_tdi = '0;
`ifdef JTAG_SCAN_MASTER_MSB_FIRST_EN
    logic               cmd_msb_first = 1'b0;
`endif
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_tdo;
    logic               busy, tck, tms, tdi, tdo;

    jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_tdi(cmd_tdi),
`ifdef JTAG_SCAN_MASTER_MSB_FIRST_EN
        .cmd_msb_first(cmd_msb_first),
`endif
        .rsp_valid(rsp_valid), .rsp_tdo(rsp_tdo), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural target TAP: 32-bit DR, 5-bit IR.
    typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
                              SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR} tap_e;
    tap_e        tap = TLR;
    logic [31:0] dr = '0, dr_upd = '0, dr_cap = '0;
    logic [4:0]  ir = '0, ir_upd = 5'h01, ir_cap = 5'h01;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:    return m ? TLR : RTI;
            RTI:    return m ? SEL_DR : RTI;
            SEL_DR: return m ? SEL_IR : CAP_DR;
            CAP_DR: return m ? EX1_DR : SH_DR;
            SH_DR:  return m ? EX1_DR : SH_DR;
            EX1_DR: return m ? UPD_DR : PAU_DR;
            PAU_DR: return m ? EX2_DR : PAU_DR;
            EX2_DR: return m ? UPD_DR : SH_DR;
            UPD_DR: return m ? SEL_DR : RTI;
            SEL_IR: return m ? TLR : CAP_IR;
            CAP_IR: return m ? EX1_IR : SH_IR;
            SH_IR:  return m ? EX1_IR : SH_IR;
            EX1_IR: return m ? UPD_IR : PAU_IR;
            PAU_IR: return m ? EX2_IR : PAU_IR;
            EX2_IR: return m ? UPD_IR : SH_IR;
            UPD_IR: return m ? SEL_DR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap)
            CAP_DR: dr <= dr_cap;
            SH_DR:  dr <= {tdi, dr[31:1]};
            UPD_DR: dr_upd <= dr;
            CAP_IR: ir <= ir_cap;
            SH_IR:  ir <= {tdi, ir[4:1]};
            UPD_IR: ir_upd <= ir;
            TLR:    ir_upd <= 5'h01;
            default: ;
        endcase
        tap <= tap_next(tap, tms);
    end

    assign tdo = (tap == SH_DR) ? dr[0] : (tap == SH_IR) ? ir[0] : 1'b0;

    // Bit stream seen by the target: bit k = value at the k-th tck rise.
    int          n_tck = 0;
    logic [63:0] tms_vec = '0, tdi_vec = '0;
    always @(posedge tck) begin
        if (n_tck < 64) begin
            tms_vec[n_tck] = tms;
            tdi_vec[n_tck] = tdi;
        end
        n_tck++;
    end

    task automatic clear_log();
        n_tck   = 0;
        tms_vec = '0;
        tdi_vec = '0;
    endtask

    typedef struct {
        logic [31:0] tdo;
        int          due;
        string       name;
    } exp_t;
    exp_t sb[$];

    always @(negedge clock) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_rsp_tdo"}, rsp_tdo, e.tdo);
                check({e.name, "_rsp_latency"}, cyc, e.due);
            end
        end
    end

    task automatic wait_ready(input string name);
        for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clock);
        if (!cmd_ready) check({name, "_ready_timeout"}, cmd_ready, 1'b1);
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic issue(input logic [1:0] op, input int len, input logic [31:0] data,
                         input logic [31:0] exp_tdo, input int ntck, input string name,
                         input bit expect_rsp);
        exp_t e;
        wait_ready(name);
        clear_log();
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_tdi   = data;
        cmd_valid = 1'b1;
        if (expect_rsp) begin
            e.tdo  = exp_tdo;
            e.due  = cyc + 2 * CLK_DIV * ntck + 1;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clock);
        check({name, "_rsp_seen"}, sb.size(), 0);
    endtask

    task automatic check_tap_reset_release(input string name);
        int t0, lat;
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (cmd_ready) begin
                lat = cyc - t0;
                break;
            end
        end
        check({name, "_ready_latency"}, (lat >= 23 && lat <= 25) ? 24 : lat, 24);
        check({name, "_ntck"}, n_tck, 6);
        check({name, "_tms"}, tms_vec, 64'h1F);
        check({name, "_tap_rti"}, tap, RTI);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_pins", {tck, tms, tdi, cmd_ready, rsp_valid, busy}, 6'b010001);
        check("reset_rsp_tdo", rsp_tdo, 0);
        clear_log();
        reset = 1'b0;
        check_tap_reset_release("auto_taprst");

        dr_cap = 32'h3C;
        issue(2'b00, 8, 32'hA5, 32'h3C, 13, "dr8", 1);
        wait_rsp("dr8");
        check("dr8_ntck", n_tck, 13);
        check("dr8_tms", tms_vec, 64'hC01);
        check("dr8_tdi", tdi_vec, 64'h528);
        check("dr8_tap_rti", tap, RTI);
        repeat (5) @(negedge clock);
        check("dr8_rsp_hold", rsp_tdo, 32'h3C);

        issue(2'b11, 0, 32'h0, 32'h0, 0, "rti0", 1);
        wait_rsp("rti0");
        check("rti0_ntck", n_tck, 0);

        ir_cap = 5'h01;
        issue(2'b01, 5, 32'h1F, 32'h01, 11, "ir5", 1);
        wait_rsp("ir5");
        check("ir5_ntck", n_tck, 11);
        check("ir5_tms", tms_vec, 64'h303);
        check("ir5_tdi", tdi_vec, 64'h1F0);
        check("ir5_ir_value", ir_upd, 5'h1F);
        check("ir5_tap_rti", tap, RTI);

        issue(2'b11, 3, 32'hFFFF_FFFF, 32'h0, 3, "rti3", 1);
        wait_rsp("rti3");
        check("rti3_ntck", n_tck, 3);
        check("rti3_tms", tms_vec, 64'h0);
        check("rti3_tdi", tdi_vec, 64'h0);

        issue(2'b10, 7, 32'h0, 32'h0, 6, "taprst_op", 1);
        wait_rsp("taprst_op");
        check("taprst_op_ntck", n_tck, 6);
        check("taprst_op_tms", tms_vec, 64'h1F);
        check("taprst_op_tap_rti", tap, RTI);

        // Length 63 is clamped to a 32-bit scan.
        dr_cap = 32'hCAFE_F00D;
        issue(2'b00, 63, 32'h0F0F_0F0F, 32'hCAFE_F00D, 37, "dr_clamp", 1);
        wait_rsp("dr_clamp");
        check("dr_clamp_ntck", n_tck, 37);
        check("dr_clamp_tms", tms_vec, 64'h0000_000C_0000_0001);
        check("dr_clamp_tdi", tdi_vec, 64'h7878_7878);
        check("dr_clamp_dr_value", dr_upd, 32'h0F0F_0F0F);

        issue(2'b00, 32, 32'h5555_5555, 32'h0, 37, "dr_abort", 0);
        repeat (30) @(negedge clock);
        check("dr_abort_in_shift", tap, SH_DR);
        reset = 1'b1;
        @(negedge clock);
        check("abort_pins", {tck, tms, tdi, cmd_ready, rsp_valid, busy}, 6'b010001);
        clear_log();
        reset = 1'b0;
        check_tap_reset_release("abort_taprst");

        dr_cap = 32'h1234_5678;
        issue(2'b00, 32, 32'hDEAD_BEEF, 32'h1234_5678, 37, "dr32", 1);
        wait_rsp("dr32");
        check("dr32_ntck", n_tck, 37);
        check("dr32_dr_value", dr_upd, 32'hDEAD_BEEF);
        check("dr32_tap_rti", tap, RTI);

`ifdef JTAG_SCAN_MASTER_MSB_FIRST_EN
        dr_cap        = 32'h3;
        cmd_msb_first = 1'b1;
        issue(2'b00, 4, 32'h8, 32'hC, 9, "msb4", 1);
        cmd_msb_first = 1'b0;
        wait_rsp("msb4");
        check("msb4_ntck", n_tck, 9);
        check("msb4_tms", tms_vec, 64'hC1);
        check("msb4_tdi", tdi_vec, 64'h8);
`endif

        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
